// File: rtl/countdown_digits.sv
// Multi-digit BCD countdown timer with active-low 7-segment outputs and a one-cycle expiry pulse.
// Optional DONE-state display blink is enabled by defining DONE_BLINK_EN.
module countdown_digits #(
    parameter int unsigned NUM_DIGITS  = 2,
    parameter int unsigned START_VALUE = 12,
    parameter int unsigned TICK_DIV    = 50,
    parameter int unsigned BLINK_DIV   = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    load,
    output logic                    running,
    output logic                    expired,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [7*NUM_DIGITS-1:0] segs
);
    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV);

    function automatic logic [DW-1:0] to_bcd(input int unsigned value);
        logic [DW-1:0] bcd;
        int unsigned   rest;
        bcd  = '0;
        rest = value;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(rest % 10);
            rest          = rest / 10;
        end
        return bcd;
    endfunction

    // Borrow ripples upward: every digit sitting at 0 wraps to 9 until one can absorb it.
    function automatic logic [DW-1:0] dec_bcd(input logic [DW-1:0] value);
        logic [DW-1:0] res;
        logic          borrow;
        res    = value;
        borrow = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                end else begin
                    res[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    localparam logic [DW-1:0] START_BCD  = to_bcd(START_VALUE);
    localparam logic [DW-1:0] ONE_BCD    = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] digits_q, digits_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          expired_q, expired_d;
    logic          running_q, running_d;
    logic          count;

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        presc_d   = presc_q;
        expired_d = 1'b0;
        count     = 1'b0;
        if (load) begin
            state_d  = IDLE;
            digits_d = START_BCD;
            presc_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        presc_d = '0;
                        if (START_VALUE == 0) begin
                            state_d   = DONE;
                            digits_d  = '0;
                            expired_d = 1'b1;
                        end else begin
                            state_d  = RUN;
                            digits_d = START_BCD;
                        end
                    end
                end
                RUN: begin
                    if (pause) state_d = PAUSED;
                    else       count   = 1'b1;
                end
                PAUSED: begin
                    // The resume edge counts as a running edge, so the held prescaler advances here.
                    if (!pause) begin
                        state_d = RUN;
                        count   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (count) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (digits_q == ONE_BCD) begin
                        digits_d  = '0;
                        state_d   = DONE;
                        expired_d = 1'b1;
                    end else begin
                        digits_d = dec_bcd(digits_q);
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            digits_q  <= START_BCD;
            presc_q   <= '0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
            running_q <= running_d;
        end
    end

    logic [7*NUM_DIGITS-1:0] segs_raw;

    always_comb begin
        segs_raw = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            segs_raw[7*i +: 7] = seg7(digits_q[4*i +: 4]);
        end
    end

`ifdef DONE_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;

    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (state_q == DONE && state_d == DONE) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_off_d = blink_off_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign segs = blink_off_q ? '1 : segs_raw;
`else
    assign segs = segs_raw;
`endif

    assign digits  = digits_q;
    assign running = running_q;
    assign expired = expired_q;

endmodule
